memory_arbiter: RTL



---
 rtl/memory_arbiter_if.sv | 33 +++
 rtl/memory_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: requester-side and RAM-side signals of the shared memory port.
`default_nettype none

interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter: shares one RAM port between instruction fetch and data access.
// Data has priority; a streak counter bounds instruction starvation.
// Optional macro ARB_STATS_EN adds grant/forced statistics counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_arbiter #(
  parameter int DSTREAK_MAX = 4,
  parameter int STREAK_W    = 3
) (
  input  wire logic         CLK,
  input  wire logic         nRST,
  memory_arbiter_if.master  bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       igrants,
  output logic [31:0]       dgrants,
  output logic [15:0]       forced
`endif
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(DSTREAK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t              r_state;
  logic [STREAK_W-1:0] r_streak;

  logic w_dreq;
  logic w_access;
  logic w_force_i;

  assign w_dreq    = bus.dREN | bus.dWEN;
  assign w_access  = (bus.ramstate == RAM_ACCESS);
  assign w_force_i = w_dreq & bus.iREN & (r_streak == STREAK_LIM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dreq && !w_force_i)
            r_state <= DGNT;
          else if (bus.iREN)
            r_state <= IGNT;
        end
        IGNT: begin
          if (w_access) begin
            r_state  <= IDLE;
            r_streak <= '0;
          end else if (!bus.iREN) begin
            r_state <= IDLE;
          end
        end
        DGNT: begin
          // Only data completions with a waiting fetch extend the streak.
          if (w_access) begin
            r_state <= IDLE;
            if (!bus.iREN)
              r_streak <= '0;
            else if (r_streak != STREAK_LIM)
              r_streak <= r_streak + 1'b1;
          end else if (!w_dreq) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (r_state)
      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
      end
      default: ;
    endcase
  end

  assign bus.iwait = ~((r_state == IGNT) & w_access);
  assign bus.dwait = ~((r_state == DGNT) & w_access);
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      igrants <= '0;
      dgrants <= '0;
      forced  <= '0;
    end else begin
      if ((r_state == IGNT) && w_access)
        igrants <= igrants + 32'd1;
      if ((r_state == DGNT) && w_access)
        dgrants <= dgrants + 32'd1;
      if ((r_state == IDLE) && w_force_i)
        forced <= forced + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
